// File: rtl/calc_core_param_pkg.sv
// Shared constants for the parametrised keypad calculator: key codes, op codes,
// FSM state encodings and data_out field offsets (relative to WIDTH).
package calc_core_param_pkg;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_ASS  = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {
    SUMA  = 2'd0,
    RESTA = 2'd1,
    MULT  = 2'd2,
    DIV   = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LHS     = 3'd1,
    ST_OP_WAIT = 3'd2,
    ST_RHS     = 3'd3,
    ST_EXEC    = 3'd4,
    ST_RESULT  = 3'd5,
    ST_ERROR   = 3'd6
  } state_t;

  // data_out[WIDTH + DOUT_ERR_OFS] = error, data_out[WIDTH + DOUT_NEG_OFS] = negative
  localparam int unsigned DOUT_ERR_OFS = 32'd1;
  localparam int unsigned DOUT_NEG_OFS = 32'd0;

endpackage

// File: rtl/calc_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock. The first step runs on
// the start edge, so done pulses exactly BITS cycles after start (BITS >= 2).
module calc_seq_divider #(
  parameter int unsigned BITS = 14
) (
  input  logic            clk,
  input  logic            reset_in,
  input  logic            start,
  input  logic [BITS-1:0] dividend,
  input  logic [BITS-1:0] divisor,
  output logic [BITS-1:0] quotient,
  output logic            done
);

  localparam int unsigned CW = $clog2(BITS + 1);

  logic [BITS-1:0]   rem_r;
  logic [BITS-1:0]   quo_r;
  logic [BITS-1:0]   den_r;
  logic [CW-1:0]     cnt_r;
  logic              done_r;
  logic [2*BITS-1:0] step_s;

  // Borrow out of the trial subtraction decides the quotient bit; the remainder
  // always stays below the divisor so BITS bits are enough to hold it.
  function automatic logic [2*BITS-1:0] div_step(input logic [BITS-1:0] rem,
                                                 input logic [BITS-1:0] quo,
                                                 input logic [BITS-1:0] den);
    logic [BITS:0] sh;
    logic [BITS:0] trial;
    sh    = {rem, quo[BITS-1]};
    trial = sh - {1'b0, den};
    if (trial[BITS] == 1'b0) begin
      return {trial[BITS-1:0], quo[BITS-2:0], 1'b1};
    end else begin
      return {sh[BITS-1:0], quo[BITS-2:0], 1'b0};
    end
  endfunction

  // one restoring step on the freshly presented operands or the running state
  always_comb begin
    if (start) begin
      step_s = div_step({BITS{1'b0}}, dividend, divisor);
    end else begin
      step_s = div_step(rem_r, quo_r, den_r);
    end
  end

  // iteration registers and done pulse
  always_ff @(posedge clk) begin
    if (reset_in) begin
      rem_r  <= '0;
      quo_r  <= '0;
      den_r  <= '0;
      cnt_r  <= '0;
      done_r <= 1'b0;
    end else if (start) begin
      {rem_r, quo_r} <= step_s;
      den_r          <= divisor;
      cnt_r          <= CW'(BITS - 32'd1);
      done_r         <= 1'b0;
    end else if (cnt_r != '0) begin
      {rem_r, quo_r} <= step_s;
      cnt_r          <= cnt_r - CW'(32'd1);
      done_r         <= (cnt_r == CW'(32'd1));
    end else begin
      done_r <= 1'b0;
    end
  end

  assign quotient = quo_r;
  assign done     = done_r;

endmodule

// File: rtl/calc_core_param.sv
// Keypad calculator core: decimal entry, signed +,-,*, multi-cycle divide, chaining.
// Optional macro CALC_REPEAT_EQ_EN: EQUAL in RESULT re-applies the last op/rhs.
module calc_core_param
  import calc_core_param_pkg::*;
#(
  parameter int unsigned WIDTH   = 14,
  parameter int unsigned MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             data_ready,
  input  logic [3:0]       key_code,
  output logic [WIDTH+1:0] data_out,
  output logic             busy
);

  localparam int unsigned ERR_BIT = WIDTH + DOUT_ERR_OFS;
  localparam int unsigned NEG_BIT = WIDTH + DOUT_NEG_OFS;

  state_t           state_r, state_nxt_s;
  op_t              op_r, op_nxt_s, chain_op_r, chain_op_nxt_s, key_op_s, ex_op_s;
  logic [WIDTH-1:0] lhs_r, lhs_nxt_s, rhs_r, rhs_nxt_s, res_r, res_nxt_s;
  logic             lhs_neg_r, lhs_neg_nxt_s, res_neg_r, res_neg_nxt_s;
  logic             chain_r, chain_nxt_s, div_neg_r, div_neg_nxt_s;
  logic [WIDTH+1:0] data_out_r, dout_nxt_s, arith_s;
  logic             busy_r, busy_nxt_s;
  logic             key_ok_s, is_digit_s, is_op_s, is_hash_s, is_ce_s;
  logic             do_exec_s, ex_chain_s, ex_neg_s, div_start_s, div_done_s;
  logic [WIDTH-1:0] ex_lhs_s, ex_rhs_s, div_q_s;
`ifdef CALC_REPEAT_EQ_EN
  op_t              last_op_r, last_op_nxt_s;
  logic [WIDTH-1:0] last_rhs_r, last_rhs_nxt_s;
`endif

  // Appends a decimal digit; a digit that would push past MAX_VAL is dropped.
  function automatic logic [WIDTH-1:0] digit_concat(input logic [WIDTH-1:0] cur,
                                                    input logic [3:0] dig);
    logic [WIDTH+3:0] wide;
    wide = (WIDTH+4)'(cur) * (WIDTH+4)'(32'd10) + (WIDTH+4)'(dig);
    if (wide > (WIDTH+4)'(MAX_VAL)) begin
      return cur;
    end else begin
      return wide[WIDTH-1:0];
    end
  endfunction

  // Add/sub/mul on sign-magnitude operands; returns a word laid out like data_out.
  function automatic logic [WIDTH+1:0] arith(input op_t op, input logic a_neg,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH+1:0]   sa, sb, sum, smag;
    logic [2*WIDTH-1:0] prod;
    logic               err, neg;
    logic [WIDTH-1:0]   mag;
    sa   = a_neg ? -{2'b00, a} : {2'b00, a};
    sb   = {2'b00, b};
    sum  = (op == RESTA) ? (sa - sb) : (sa + sb);
    prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    err  = 1'b0;
    neg  = 1'b0;
    mag  = '0;
    case (op)
      SUMA, RESTA: begin
        neg  = sum[WIDTH+1];
        smag = neg ? -sum : sum;
        err  = (smag > (WIDTH+2)'(MAX_VAL));
        mag  = smag[WIDTH-1:0];
      end
      MULT: begin
        err = (prod > (2*WIDTH)'(MAX_VAL));
        neg = a_neg;
        mag = prod[WIDTH-1:0];
      end
      default: begin
        err = 1'b0;
      end
    endcase
    if (mag == '0) begin
      neg = 1'b0;
    end else begin
      neg = neg;
    end
    if (err) begin
      return {1'b1, {(WIDTH+1){1'b0}}};
    end else begin
      return {1'b0, neg, mag};
    end
  endfunction

  assign key_ok_s   = data_ready && !busy_r;
  assign is_digit_s = (key_code <= KEY_9);
  assign is_op_s    = (key_code >= KEY_A) && (key_code <= KEY_D);
  assign is_hash_s  = (key_code == KEY_HASH);
  assign is_ce_s    = (key_code == KEY_ASS);

  // keypad letter to operator
  always_comb begin
    case (key_code)
      KEY_A:   key_op_s = SUMA;
      KEY_B:   key_op_s = RESTA;
      KEY_C:   key_op_s = MULT;
      KEY_D:   key_op_s = DIV;
      default: key_op_s = SUMA;
    endcase
  end

  calc_seq_divider #(.BITS(WIDTH)) u_div (
    .clk      (clk),
    .reset_in (reset_in),
    .start    (div_start_s),
    .dividend (ex_lhs_s),
    .divisor  (ex_rhs_s),
    .quotient (div_q_s),
    .done     (div_done_s)
  );

  // next-state and datapath update
  always_comb begin
    state_nxt_s    = state_r;
    op_nxt_s       = op_r;
    lhs_nxt_s      = lhs_r;
    lhs_neg_nxt_s  = lhs_neg_r;
    rhs_nxt_s      = rhs_r;
    res_nxt_s      = res_r;
    res_neg_nxt_s  = res_neg_r;
    chain_nxt_s    = chain_r;
    chain_op_nxt_s = chain_op_r;
    div_neg_nxt_s  = div_neg_r;
    div_start_s    = 1'b0;
    do_exec_s      = 1'b0;
    ex_chain_s     = 1'b0;
    ex_op_s        = op_r;
    ex_neg_s       = lhs_neg_r;
    ex_lhs_s       = lhs_r;
    ex_rhs_s       = rhs_r;
    arith_s        = '0;
`ifdef CALC_REPEAT_EQ_EN
    last_op_nxt_s  = last_op_r;
    last_rhs_nxt_s = last_rhs_r;
`endif
    if (key_ok_s && is_ce_s) begin
      state_nxt_s    = ST_IDLE;
      op_nxt_s       = SUMA;
      lhs_nxt_s      = '0;
      lhs_neg_nxt_s  = 1'b0;
      rhs_nxt_s      = '0;
      res_nxt_s      = '0;
      res_neg_nxt_s  = 1'b0;
      chain_nxt_s    = 1'b0;
      chain_op_nxt_s = SUMA;
      div_neg_nxt_s  = 1'b0;
`ifdef CALC_REPEAT_EQ_EN
      last_op_nxt_s  = SUMA;
      last_rhs_nxt_s = '0;
`endif
    end else if (state_r == ST_EXEC) begin
      if (div_done_s) begin
        res_nxt_s     = div_q_s;
        res_neg_nxt_s = div_neg_r && (div_q_s != '0);
        chain_nxt_s   = 1'b0;
        if (chain_r) begin
          state_nxt_s   = ST_OP_WAIT;
          lhs_nxt_s     = div_q_s;
          lhs_neg_nxt_s = div_neg_r && (div_q_s != '0);
          op_nxt_s      = chain_op_r;
        end else begin
          state_nxt_s = ST_RESULT;
        end
      end else begin
        state_nxt_s = ST_EXEC;
      end
    end else if (key_ok_s) begin
      case (state_r)
        ST_IDLE: begin
          if (is_digit_s) begin
            lhs_nxt_s     = WIDTH'(key_code);
            lhs_neg_nxt_s = 1'b0;
            state_nxt_s   = ST_LHS;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_LHS: begin
          if (is_digit_s) begin
            lhs_nxt_s = digit_concat(lhs_r, key_code);
          end else if (is_op_s) begin
            op_nxt_s    = key_op_s;
            state_nxt_s = ST_OP_WAIT;
          end else if (is_hash_s) begin
            res_nxt_s     = lhs_r;
            res_neg_nxt_s = lhs_neg_r;
            state_nxt_s   = ST_RESULT;
          end else begin
            state_nxt_s = ST_LHS;
          end
        end
        ST_OP_WAIT: begin
          if (is_digit_s) begin
            rhs_nxt_s   = WIDTH'(key_code);
            state_nxt_s = ST_RHS;
          end else if (is_op_s) begin
            op_nxt_s = key_op_s;
          end else if (is_hash_s) begin
            res_nxt_s     = lhs_r;
            res_neg_nxt_s = lhs_neg_r;
            state_nxt_s   = ST_RESULT;
          end else begin
            state_nxt_s = ST_OP_WAIT;
          end
        end
        ST_RHS: begin
          if (is_digit_s) begin
            rhs_nxt_s = digit_concat(rhs_r, key_code);
          end else if (is_op_s || is_hash_s) begin
            do_exec_s  = 1'b1;
            ex_chain_s = is_op_s;
`ifdef CALC_REPEAT_EQ_EN
            last_op_nxt_s  = op_r;
            last_rhs_nxt_s = rhs_r;
`endif
          end else begin
            state_nxt_s = ST_RHS;
          end
        end
        ST_RESULT: begin
          if (is_digit_s) begin
            lhs_nxt_s     = WIDTH'(key_code);
            lhs_neg_nxt_s = 1'b0;
            state_nxt_s   = ST_LHS;
          end else if (is_op_s) begin
            lhs_nxt_s     = res_r;
            lhs_neg_nxt_s = res_neg_r;
            op_nxt_s      = key_op_s;
            state_nxt_s   = ST_OP_WAIT;
          end else if (is_hash_s) begin
`ifdef CALC_REPEAT_EQ_EN
            lhs_nxt_s     = res_r;
            lhs_neg_nxt_s = res_neg_r;
            do_exec_s     = 1'b1;
            ex_op_s       = last_op_r;
            ex_neg_s      = res_neg_r;
            ex_lhs_s      = res_r;
            ex_rhs_s      = last_rhs_r;
`else
            state_nxt_s = ST_RESULT;
`endif
          end else begin
            state_nxt_s = ST_RESULT;
          end
        end
        ST_ERROR: state_nxt_s = ST_ERROR;
        ST_EXEC:  state_nxt_s = ST_EXEC;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end

    // evaluation of the pending op; divide hands off to the sequential divider
    if (do_exec_s) begin
      arith_s = arith(ex_op_s, ex_neg_s, ex_lhs_s, ex_rhs_s);
      if (ex_op_s == DIV) begin
        if (ex_rhs_s == '0) begin
          state_nxt_s = ST_ERROR;
        end else begin
          div_start_s    = 1'b1;
          div_neg_nxt_s  = ex_neg_s;
          chain_nxt_s    = ex_chain_s;
          chain_op_nxt_s = key_op_s;
          state_nxt_s    = ST_EXEC;
        end
      end else if (arith_s[ERR_BIT]) begin
        state_nxt_s = ST_ERROR;
      end else begin
        res_nxt_s     = arith_s[WIDTH-1:0];
        res_neg_nxt_s = arith_s[NEG_BIT];
        if (ex_chain_s) begin
          lhs_nxt_s     = arith_s[WIDTH-1:0];
          lhs_neg_nxt_s = arith_s[NEG_BIT];
          op_nxt_s      = key_op_s;
          state_nxt_s   = ST_OP_WAIT;
        end else begin
          state_nxt_s = ST_RESULT;
        end
      end
    end else begin
      arith_s = '0;
    end
  end

  // display source follows the state being entered
  always_comb begin
    case (state_nxt_s)
      ST_IDLE, ST_LHS, ST_OP_WAIT: dout_nxt_s = {1'b0, lhs_neg_nxt_s, lhs_nxt_s};
      ST_RHS:                      dout_nxt_s = {2'b00, rhs_nxt_s};
      ST_RESULT:                   dout_nxt_s = {1'b0, res_neg_nxt_s, res_nxt_s};
      ST_ERROR:                    dout_nxt_s = {1'b1, {(WIDTH+1){1'b0}}};
      ST_EXEC:                     dout_nxt_s = data_out_r;
      default:                     dout_nxt_s = data_out_r;
    endcase
    busy_nxt_s = (state_nxt_s == ST_EXEC);
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // operand, result and output registers
  always_ff @(posedge clk) begin
    if (reset_in) begin
      op_r       <= SUMA;
      lhs_r      <= '0;
      lhs_neg_r  <= 1'b0;
      rhs_r      <= '0;
      res_r      <= '0;
      res_neg_r  <= 1'b0;
      chain_r    <= 1'b0;
      chain_op_r <= SUMA;
      div_neg_r  <= 1'b0;
      data_out_r <= '0;
      busy_r     <= 1'b0;
`ifdef CALC_REPEAT_EQ_EN
      last_op_r  <= SUMA;
      last_rhs_r <= '0;
`endif
    end else begin
      op_r       <= op_nxt_s;
      lhs_r      <= lhs_nxt_s;
      lhs_neg_r  <= lhs_neg_nxt_s;
      rhs_r      <= rhs_nxt_s;
      res_r      <= res_nxt_s;
      res_neg_r  <= res_neg_nxt_s;
      chain_r    <= chain_nxt_s;
      chain_op_r <= chain_op_nxt_s;
      div_neg_r  <= div_neg_nxt_s;
      data_out_r <= dout_nxt_s;
      busy_r     <= busy_nxt_s;
`ifdef CALC_REPEAT_EQ_EN
      last_op_r  <= last_op_nxt_s;
      last_rhs_r <= last_rhs_nxt_s;
`endif
    end
  end

  assign data_out = data_out_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_calc_core_param.sv
// Directed self-checking bench for calc_core_param (WIDTH=14, MAX_VAL=9999).
module tb_calc_core_param;

  localparam logic [31:0] ERR_WORD = 32'h0000_8000;
  localparam logic [31:0] NEG_BIT  = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        data_ready = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [15:0] data_out;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cycles;
  int guard;

  calc_core_param #(.WIDTH(14), .MAX_VAL(9999)) dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .data_ready (data_ready),
    .key_code   (key_code),
    .data_out   (data_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // one-cycle strobe; returns on the falling edge after the accepting clock
  task automatic send(input logic [3:0] k);
    @(negedge clk);
    data_ready = 1'b1;
    key_code   = k;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (busy === 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    check_val(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_in = 1'b0;
    check_val("reset_dout", {16'd0, data_out}, 32'd0);
    check_val("reset_busy", {31'd0, busy}, 32'd0);

    // 1: add, then repeat-equals
    send(4'd1); send(4'd2);
    check_val("entry_12", {16'd0, data_out}, 32'd12);
    send(4'd10); send(4'd3); send(4'd4);
    check_val("rhs_34", {16'd0, data_out}, 32'd34);
    send(4'd15);
    check_val("add_46", {16'd0, data_out}, 32'd46);
    send(4'd15);
`ifdef CALC_REPEAT_EQ_EN
    check_val("repeat_eq", {16'd0, data_out}, 32'd80);
`else
    check_val("repeat_eq", {16'd0, data_out}, 32'd46);
`endif
    send(4'd14);
    check_val("ce_clear", {16'd0, data_out}, 32'd0);

    // 2: negative result carried into next op
    send(4'd5); send(4'd11); send(4'd9); send(4'd15);
    check_val("sub_neg4", {16'd0, data_out}, NEG_BIT | 32'd4);
    send(4'd10);
    check_val("carry_neg4", {16'd0, data_out}, NEG_BIT | 32'd4);
    send(4'd6); send(4'd15);
    check_val("neg_add_2", {16'd0, data_out}, 32'd2);
    send(4'd14);

    // 3: digit overflow, multiply overflow, sticky error
    for (int i = 0; i < 5; i++) send(4'd9);
    check_val("max_9999", {16'd0, data_out}, 32'd9999);
    send(4'd12); send(4'd2); send(4'd15);
    check_val("mul_ovf", {16'd0, data_out}, ERR_WORD);
    send(4'd5); send(4'd15); send(4'd10);
    check_val("err_sticky", {16'd0, data_out}, ERR_WORD);
    send(4'd14);
    check_val("err_ce", {16'd0, data_out}, 32'd0);

    // 4: divide latency, dropped key mid-divide
    send(4'd1); send(4'd0); send(4'd0); send(4'd13); send(4'd7); send(4'd15);
    check_val("div_hold", {16'd0, data_out}, 32'd7);
    busy_cycles = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      busy_cycles++;
      if (guard == 2) begin
        data_ready = 1'b1;
        key_code   = 4'd5;
      end else begin
        data_ready = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    data_ready = 1'b0;
    check_val("div_busy_len", busy_cycles, 32'd14);
    check_val("div_100_7", {16'd0, data_out}, 32'd14);
    send(4'd14);
    send(4'd8); send(4'd13); send(4'd0); send(4'd15);
    check_val("div0_busy", {31'd0, busy}, 32'd0);
    check_val("div0_err", {16'd0, data_out}, ERR_WORD);
    send(4'd14);

    // 5: chained evaluation
    send(4'd2); send(4'd10); send(4'd3); send(4'd12);
    check_val("chain_5", {16'd0, data_out}, 32'd5);
    send(4'd4); send(4'd15);
    check_val("chain_mul_20", {16'd0, data_out}, 32'd20);
    send(4'd14);

    // chained divide, negative divide, -0 normalisation
    send(4'd9); send(4'd0); send(4'd13); send(4'd4); send(4'd10);
    wait_idle("chain_div_idle");
    check_val("chain_div_22", {16'd0, data_out}, 32'd22);
    send(4'd1); send(4'd15);
    check_val("chain_add_23", {16'd0, data_out}, 32'd23);
    send(4'd14);
    send(4'd3); send(4'd11); send(4'd9); send(4'd15);
    check_val("sub_neg6", {16'd0, data_out}, NEG_BIT | 32'd6);
    send(4'd13); send(4'd4); send(4'd15);
    wait_idle("neg_div_idle");
    check_val("neg_div_1", {16'd0, data_out}, NEG_BIT | 32'd1);
    send(4'd12); send(4'd0); send(4'd15);
    check_val("neg_zero", {16'd0, data_out}, 32'd0);
    send(4'd14);

    // 6: reset mid-divide
    send(4'd1); send(4'd0); send(4'd0); send(4'd13); send(4'd7); send(4'd15);
    repeat (4) @(negedge clk);
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
    check_val("rst_mid_dout", {16'd0, data_out}, 32'd0);
    send(4'd3); send(4'd15);
    check_val("post_rst_3", {16'd0, data_out}, 32'd3);
    repeat (20) @(negedge clk);
    check_val("post_rst_stable", {16'd0, data_out}, 32'd3);
    check_val("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
